// File: rtl/apb_mem_model_pkg.sv
// Shared types, widths and the LFSR step for the APB memory model.
package apb_mem_model_pkg;

  typedef enum logic [1:0] {WAIT_NONE, WAIT_FIXED, WAIT_RANDOM} wait_mode_e;
  typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS} apb_state_e;

  localparam int unsigned CNT_W     = 8;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;  // taps 16,14,13,11

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/apb_wait_gen.sv
// Wait-state generator: mode mux plus a free LFSR that steps once per accepted setup.
module apb_wait_gen
  import apb_mem_model_pkg::*;
#(
  parameter wait_mode_e  WAIT_MODE   = WAIT_NONE,
  parameter int unsigned FIXED_WAITS = 2,
  parameter int unsigned MAX_WAITS   = 3,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  output logic [CNT_W-1:0] wait_cnt
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  // The count reflects the LFSR value before this load advances it.
  always_comb begin
    wait_cnt = '0;
    unique case (WAIT_MODE)
      WAIT_NONE:   wait_cnt = '0;
      WAIT_FIXED:  wait_cnt = CNT_W'(FIXED_WAITS);
      WAIT_RANDOM: wait_cnt = CNT_W'(lfsr_q & 16'(MAX_WAITS));
      default:     wait_cnt = '0;
    endcase
  end

endmodule

// File: rtl/apb_mem_model.sv
// APB3 slave memory with byte strobes, configurable wait states, error response
// and halt / tohost end-of-test detection.
module apb_mem_model
  import apb_mem_model_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter wait_mode_e  WAIT_MODE   = WAIT_NONE,
  parameter int unsigned FIXED_WAITS = 2,
  parameter int unsigned MAX_WAITS   = 3,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter string       INIT_FILE   = "",
  parameter logic [31:0] HALT_WORD   = 32'h0000006f,
  parameter logic [31:0] TOHOST_ADDR = 32'hFFFF_FFF0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         paddr,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  output logic [DATA_W-1:0]   prdata,
  output logic                pready,
  output logic                pslverr,
  output logic                halt_o,
  output logic                done_o,
  output logic [DATA_W-1:0]   tohost_o
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  apb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, wait_cnt;
  logic [31:0]       addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] strb_q;
  logic              pready_q, pready_d, pslverr_q, pslverr_d;
  logic [DATA_W-1:0] prdata_q, prdata_d, tohost_q;
  logic              halt_q, done_q;

  logic        accept, complete, mem_we;
  logic [31:0] src_addr, off, idx;
  logic        src_write, is_tohost, is_err;

  assign accept = (state_q == APB_IDLE) && psel && !penable;

  apb_wait_gen #(
    .WAIT_MODE  (WAIT_MODE),
    .FIXED_WAITS(FIXED_WAITS),
    .MAX_WAITS  (MAX_WAITS),
    .LFSR_SEED  (LFSR_SEED)
  ) u_wait_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .wait_cnt(wait_cnt)
  );

  // Decode the live bus while idle so a zero-wait response can be registered
  // at the setup edge; afterwards decode the latched request.
  always_comb begin
    src_addr  = (state_q == APB_IDLE) ? paddr  : addr_q;
    src_write = (state_q == APB_IDLE) ? pwrite : write_q;
    off       = src_addr - BASE_ADDR;
    idx       = off >> OFF_W;
    is_tohost = (src_addr == TOHOST_ADDR);
    is_err    = !is_tohost && ((off[OFF_W-1:0] != '0) || (idx >= DEPTH));
  end

  assign complete = pready_q && psel && penable && (state_q != APB_IDLE);
  assign mem_we   = complete && write_q && !pslverr_q && !is_tohost && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= APB_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      APB_IDLE: begin
        if (accept) begin
          state_d = APB_SETUP;
          cnt_d   = wait_cnt;
        end
      end
      APB_SETUP, APB_ACCESS: begin
        if (!psel) begin
          state_d = APB_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = APB_IDLE;
        end else begin
          state_d = APB_ACCESS;
          cnt_d   = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = APB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // pready is registered one cycle ahead: it is high in exactly the cycle the
  // FSM sits in SETUP/ACCESS with an exhausted wait count.
  always_comb begin
    pready_d  = (state_d != APB_IDLE) && (cnt_d == '0);
    pslverr_d = pready_d && is_err;
    prdata_d  = prdata_q;
    if (pready_d) begin
      if (is_err)          prdata_d = '0;
      else if (!src_write) prdata_d = is_tohost ? '0 : mem[idx[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      halt_q    <= 1'b0;
      done_q    <= 1'b0;
      tohost_q  <= '0;
    end else begin
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      if (complete && !write_q && !pslverr_q && (prdata_q[31:0] == HALT_WORD)) halt_q <= 1'b1;
      if (complete && write_q && is_tohost) begin
        done_q <= 1'b1;
        if (!done_q) tohost_q <= wdata_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= paddr;
      write_q <= pwrite;
      wdata_q <= pwdata;
      strb_q  <= pstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (strb_q[b]) mem[idx[AW-1:0]][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign prdata   = prdata_q;
  assign pready   = pready_q;
  assign pslverr  = pslverr_q;
  assign halt_o   = halt_q;
  assign done_o   = done_q;
  assign tohost_o = tohost_q;

endmodule

// File: tb/tb_apb_mem_model.sv
// Directed bench: three instances (no / fixed / random waits) share one APB bus.
module tb_apb_mem_model;
  import apb_mem_model_pkg::*;

  localparam logic [31:0] TOHOST = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] paddr = '0;
  logic        penable = 1'b0, pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic [2:0]  psel = '0;
  logic [2:0]  pready, pslverr, halt, done;
  logic [2:0][31:0] prdata, tohost;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  apb_mem_model #(.WAIT_MODE(WAIT_NONE)) u_none (
    .clk(clk), .rst(rst), .paddr(paddr), .psel(psel[0]), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata[0]), .pready(pready[0]),
    .pslverr(pslverr[0]), .halt_o(halt[0]), .done_o(done[0]), .tohost_o(tohost[0])
  );

  apb_mem_model #(.WAIT_MODE(WAIT_FIXED), .FIXED_WAITS(2)) u_fixed (
    .clk(clk), .rst(rst), .paddr(paddr), .psel(psel[1]), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata[1]), .pready(pready[1]),
    .pslverr(pslverr[1]), .halt_o(halt[1]), .done_o(done[1]), .tohost_o(tohost[1])
  );

  apb_mem_model #(.WAIT_MODE(WAIT_RANDOM), .MAX_WAITS(3), .LFSR_SEED(16'hACE1)) u_rand (
    .clk(clk), .rst(rst), .paddr(paddr), .psel(psel[2]), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata[2]), .pready(pready[2]),
    .pslverr(pslverr[2]), .halt_o(halt[2]), .done_o(done[2]), .tohost_o(tohost[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference Galois LFSR, taps 16,14,13,11.
  function automatic logic [15:0] ref_lfsr(input logic [15:0] v);
    logic [15:0] s;
    s = v >> 1;
    if (v[0]) s = s ^ 16'b1011_0100_0000_0000;
    return s;
  endfunction

  // Entered and left #1 after a rising edge; lat counts edges from setup to pready.
  task automatic xfer(input int u, input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output logic er,
                      output int lat);
    paddr = a; pwrite = w; pwdata = d; pstrb = s;
    psel = '0; psel[u] = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    lat = 1;
    while (pready[u] !== 1'b1 && lat < 16) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = prdata[u];
    er = pslverr[u];
    @(posedge clk); #1;
    psel = '0; penable = 1'b0;
  endtask

  task automatic do_wr(input string tag, input int u, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int wlat, input logic werr);
    logic [31:0] rd;
    logic        er;
    int          lat;
    xfer(u, a, 1'b1, d, s, rd, er, lat);
    check({tag, ".lat"}, 32'(lat), 32'(wlat));
    check({tag, ".err"}, {31'b0, er}, {31'b0, werr});
  endtask

  task automatic do_rd(input string tag, input int u, input logic [31:0] a,
                       input logic [31:0] exp, input int wlat, input logic werr);
    logic [31:0] rd;
    logic        er;
    int          lat;
    xfer(u, a, 1'b0, 32'h0, 4'h0, rd, er, lat);
    check({tag, ".lat"}, 32'(lat), 32'(wlat));
    check({tag, ".err"}, {31'b0, er}, {31'b0, werr});
    check({tag, ".data"}, rd, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] lf;
    int          w;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst.pready", {29'b0, pready}, 32'h0);
    check("rst.pslverr", {29'b0, pslverr}, 32'h0);
    check("rst.prdata0", prdata[0], 32'h0);
    check("rst.halt", {29'b0, halt}, 32'h0);
    check("rst.done", {29'b0, done}, 32'h0);
    check("rst.tohost0", tohost[0], 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // T1: zero-wait write then read
    do_wr("t1.wr", 0, 32'h10, 32'hDEADBEEF, 4'hF, 1, 1'b0);
    do_rd("t1.rd", 0, 32'h10, 32'hDEADBEEF, 1, 1'b0);

    // T2: byte strobes and the pstrb=0 no-op
    do_wr("t2.init", 0, 32'h20, 32'h11223344, 4'hF, 1, 1'b0);
    do_wr("t2.strb", 0, 32'h20, 32'hAABBCCDD, 4'b0101, 1, 1'b0);
    do_rd("t2.rd", 0, 32'h20, 32'h11BB33DD, 1, 1'b0);
    do_wr("t2.nostrb", 0, 32'h20, 32'hFFFFFFFF, 4'h0, 1, 1'b0);
    do_rd("t2.rd2", 0, 32'h20, 32'h11BB33DD, 1, 1'b0);

    // T3: two fixed waits, back-to-back transfers
    for (int i = 0; i < 8; i++)
      do_wr("t3.wr", 1, 32'h100 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1), 4'hF, 3, 1'b0);
    for (int i = 0; i < 8; i++)
      do_rd("t3.rd", 1, 32'h100 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1), 3, 1'b0);

    // T4: random waits follow the reference LFSR
    lf = 16'hACE1;
    for (int i = 0; i < 32; i++) begin
      w  = int'(lf & 16'h0003);
      lf = ref_lfsr(lf);
      do_wr("t4.wr", 2, 32'h200 + 32'(4 * i), 32'hA5A5_0000 ^ (32'h0101_0101 * 32'(i)), 4'hF,
            w + 1, 1'b0);
    end
    for (int i = 0; i < 32; i++) begin
      w  = int'(lf & 16'h0003);
      lf = ref_lfsr(lf);
      do_rd("t4.rd", 2, 32'h200 + 32'(4 * i), 32'hA5A5_0000 ^ (32'h0101_0101 * 32'(i)),
            w + 1, 1'b0);
    end

    // T5: misaligned and out-of-range accesses
    do_wr("t5.pre", 0, 32'h0, 32'h0BADF00D, 4'hF, 1, 1'b0);
    do_rd("t5.mis_rd", 0, 32'h1002, 32'h0, 1, 1'b1);
    do_wr("t5.oor_wr", 0, 32'h1000, 32'h12345678, 4'hF, 1, 1'b1);
    do_wr("t5.mis_wr", 0, 32'h11, 32'h55555555, 4'hF, 1, 1'b1);
    do_rd("t5.chk0", 0, 32'h0, 32'h0BADF00D, 1, 1'b0);
    do_rd("t5.chk10", 0, 32'h10, 32'hDEADBEEF, 1, 1'b0);

    // T6: halt word, tohost, reset in the completing cycle
    do_wr("t6.halt_wr", 0, 32'h40, 32'h0000006f, 4'hF, 1, 1'b0);
    check("t6.halt_pre", {31'b0, halt[0]}, 32'h0);
    do_rd("t6.halt_rd", 0, 32'h40, 32'h0000006f, 1, 1'b0);
    check("t6.halt", {31'b0, halt[0]}, 32'h1);
    check("t6.done_pre", {31'b0, done[0]}, 32'h0);
    do_wr("t6.th1", 0, TOHOST, 32'h1, 4'hF, 1, 1'b0);
    check("t6.done", {31'b0, done[0]}, 32'h1);
    check("t6.tohost1", tohost[0], 32'h1);
    do_wr("t6.th7", 0, TOHOST, 32'h7, 4'hF, 1, 1'b0);
    check("t6.tohost_first", tohost[0], 32'h1);
    do_rd("t6.th_rd", 0, TOHOST, 32'h0, 1, 1'b0);

    do_wr("t6.pre50", 1, 32'h50, 32'hCAFEF00D, 4'hF, 3, 1'b0);
    paddr = 32'h50; pwrite = 1'b1; pwdata = 32'h12345678; pstrb = 4'hF;
    psel = 3'b010; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t6.rdy_at_rst", {31'b0, pready[1]}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    psel = '0; penable = 1'b0;
    check("t6.rst_halt", {29'b0, halt}, 32'h0);
    check("t6.rst_done", {29'b0, done}, 32'h0);
    check("t6.rst_tohost", tohost[0], 32'h0);
    check("t6.rst_pready", {29'b0, pready}, 32'h0);
    @(posedge clk); #1;
    do_rd("t6.nowrite", 1, 32'h50, 32'hCAFEF00D, 3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
